// File: rtl/axi4l_pkg.sv
// rtl/axi4l_pkg.sv - shared AXI4-Lite types for the on-chip RAM slave
package axi4l_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  strb_t;
  typedef logic [2:0]  prot_t;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_t;

endpackage

// File: rtl/axi4l_ram32_if.sv
// rtl/axi4l_ram32_if.sv - AXI4-Lite bus bundle with master/slave views
interface axi4l_ram32_if;
  import axi4l_pkg::*;

  logic  awvalid;
  logic  awready;
  addr_t awaddr;
  prot_t awprot;
  logic  wvalid;
  logic  wready;
  data_t wdata;
  strb_t wstrb;
  logic  bvalid;
  logic  bready;
  resp_t bresp;
  logic  arvalid;
  logic  arready;
  addr_t araddr;
  prot_t arprot;
  logic  rvalid;
  logic  rready;
  data_t rdata;
  resp_t rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/dpram32_be.sv
// rtl/dpram32_be.sv - 32-bit dual-port RAM, byte-enabled write port, registered read port
module dpram32_be
  import axi4l_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  strb_t         wstrb,
  input  data_t         wdata,
  input  logic          re,
  input  logic [IW-1:0] raddr,
  output data_t         rdata
);

  data_t mem [DEPTH];

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi4l_ram32.sv
// rtl/axi4l_ram32.sv - AXI4-Lite slave over a byte-addressable dual-port RAM
module axi4l_ram32
  import axi4l_pkg::*;
#(
  parameter int SIZE = 'h10
) (
  input  logic          aclk,
  input  logic          areset,
  axi4l_ram32_if.slave  s
);

  localparam int AW    = $clog2(SIZE) - 2;
  localparam int WORDS = SIZE / 4;

  logic          valid_write_address;
  logic          valid_write_data;
  logic          valid_read_address;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;
  data_t         wdata_hold;
  strb_t         wstrb_hold;
  logic          bvalid_q;
  resp_t         bresp_q;
  logic          rvalid_q;
  resp_t         rresp_q;
  data_t         ram_rdata;

  logic write_response_stall;
  logic read_response_stall;
  logic write_fire;
  logic read_fire;

  assign write_response_stall = bvalid_q && !s.bready;
  assign read_response_stall  = rvalid_q && !s.rready;
  assign write_fire = valid_write_address && valid_write_data && !write_response_stall;
  assign read_fire  = valid_read_address && !read_response_stall;

  // Ready straight from the hold flags: no combinational path from valid to ready.
  assign s.awready = !valid_write_address;
  assign s.wready  = !valid_write_data;
  assign s.arready = !valid_read_address;
  assign s.bvalid  = bvalid_q;
  assign s.bresp   = bresp_q;
  assign s.rvalid  = rvalid_q;
  assign s.rresp   = rresp_q;
  assign s.rdata   = ram_rdata;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      valid_write_address <= 1'b0;
      waddr               <= '0;
      valid_write_data    <= 1'b0;
      wdata_hold          <= '0;
      wstrb_hold          <= '0;
      bvalid_q            <= 1'b0;
      bresp_q             <= OKAY;
    end else begin
      if (s.awvalid && !valid_write_address) begin
        valid_write_address <= 1'b1;
        waddr               <= s.awaddr[AW+1:2];
      end else if (write_fire) begin
        valid_write_address <= 1'b0;
      end

      if (s.wvalid && !valid_write_data) begin
        valid_write_data <= 1'b1;
        wdata_hold       <= s.wdata;
        wstrb_hold       <= s.wstrb;
      end else if (write_fire) begin
        valid_write_data <= 1'b0;
      end

      if (write_fire) begin
        bvalid_q <= 1'b1;
        bresp_q  <= OKAY;
      end else if (s.bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      valid_read_address <= 1'b0;
      raddr              <= '0;
      rvalid_q           <= 1'b0;
      rresp_q            <= OKAY;
    end else begin
      if (s.arvalid && !valid_read_address) begin
        valid_read_address <= 1'b1;
        raddr              <= s.araddr[AW+1:2];
      end else if (read_fire) begin
        valid_read_address <= 1'b0;
      end

      if (read_fire) begin
        rvalid_q <= 1'b1;
        rresp_q  <= OKAY;
      end else if (s.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Same-word read and write on one edge: the read register samples the old word.
  dpram32_be #(
    .DEPTH (WORDS)
  ) u_ram (
    .clk   (aclk),
    .rst   (areset),
    .we    (write_fire),
    .waddr (waddr),
    .wstrb (wstrb_hold),
    .wdata (wdata_hold),
    .re    (read_fire),
    .raddr (raddr),
    .rdata (ram_rdata)
  );

  logic unused;
  assign unused = ^{s.awprot, s.arprot, s.awaddr[31:AW+2], s.awaddr[1:0],
                    s.araddr[31:AW+2], s.araddr[1:0]};

endmodule

// File: tb/tb_axi4l_ram32.sv
// tb/tb_axi4l_ram32.sv - scoreboard bench for the AXI4-Lite RAM slave
module tb_axi4l_ram32;
  import axi4l_pkg::*;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  axi4l_ram32_if bus ();

  axi4l_ram32 #(
    .SIZE ('h10)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .s      (bus.slave)
  );

  int          n_asserts = 0;
  int          n_fail    = 0;
  logic [31:0] model [4];
  logic [31:0] rq [$];
  logic [31:0] bq [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'd3);
  endfunction

  // Response monitor: inputs only move at posedge+1, so negedge sees the edge-to-be.
  always @(negedge aclk) begin
    if (!areset && bus.rvalid && bus.rready) begin
      if (rq.size() == 0) check("r_unexpected", 32'd1, 32'd0);
      else begin
        check("rdata", bus.rdata, rq.pop_front());
        check("rresp", 32'(bus.rresp), 32'(OKAY));
      end
    end
    if (!areset && bus.bvalid && bus.bready) begin
      if (bq.size() == 0) check("b_unexpected", 32'd1, 32'd0);
      else check("bresp", 32'(bus.bresp), bq.pop_front());
    end
  end

  task automatic handshake();
    logic aw_hs, w_hs, ar_hs;
    int n = 0;
    while (bus.awvalid || bus.wvalid || bus.arvalid) begin
      @(negedge aclk);
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      ar_hs = bus.arvalid && bus.arready;
      @(posedge aclk); #1;
      if (aw_hs) bus.awvalid = 1'b0;
      if (w_hs)  bus.wvalid  = 1'b0;
      if (ar_hs) bus.arvalid = 1'b0;
      n++;
      if (n > 50) begin
        check("hs_timeout", 32'(n), 32'd0);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.arvalid = 1'b0;
      end
    end
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++)
      if (s[i]) model[widx(a)][8*i +: 8] = d[8*i +: 8];
    bq.push_back(32'(OKAY));
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    model_write(a, d, s);
    bus.awaddr = a; bus.awvalid = 1'b1;
    bus.wdata  = d; bus.wstrb   = s; bus.wvalid = 1'b1;
    handshake();
  endtask

  task automatic do_read(input logic [31:0] a);
    rq.push_back(model[widx(a)]);
    bus.araddr = a; bus.arvalid = 1'b1;
    handshake();
  endtask

  task automatic wait_valid(input string tag, input bit is_read);
    int n = 0;
    while (!(is_read ? bus.rvalid : bus.bvalid) && n < 50) begin
      @(posedge aclk); #1; n++;
    end
    check(tag, 32'(is_read ? bus.rvalid : bus.bvalid), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 100) begin
      @(posedge aclk); #1; n++;
    end
    check("drain_r", 32'(rq.size()), 32'd0);
    check("drain_b", 32'(bq.size()), 32'd0);
  endtask

  initial begin
    bus.awvalid = 1'b0; bus.awaddr = '0; bus.awprot = '0;
    bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb  = '0;
    bus.arvalid = 1'b0; bus.araddr = '0; bus.arprot = '0;
    bus.bready  = 1'b1; bus.rready = 1'b1;
    for (int i = 0; i < 4; i++) model[i] = '0;

    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    check("rst_awready", 32'(bus.awready), 32'd1);
    check("rst_wready",  32'(bus.wready),  32'd1);
    check("rst_arready", 32'(bus.arready), 32'd1);
    check("rst_bvalid",  32'(bus.bvalid),  32'd0);
    check("rst_rvalid",  32'(bus.rvalid),  32'd0);
    check("rst_rdata",   bus.rdata,        32'd0);
    check("rst_bresp",   32'(bus.bresp),   32'(OKAY));
    check("rst_rresp",   32'(bus.rresp),   32'(OKAY));

    // Single write with latency check: handshake edge N, bvalid after N+1.
    @(posedge aclk); #1;
    model_write(32'h4, 32'hDEADBEEF, 4'hF);
    bus.awaddr = 32'h4; bus.awvalid = 1'b1;
    bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge aclk);
    check("aw_w_ready", 32'({bus.awready, bus.wready}), 32'd3);
    @(posedge aclk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("b_early", 32'(bus.bvalid), 32'd0);
    @(posedge aclk); #1;
    check("b_latency", 32'(bus.bvalid), 32'd1);
    do_read(32'h4);
    drain();

    // Byte strobes
    do_write(32'h8, 32'h11223344, 4'hF);
    do_write(32'h8, 32'hAABBCCDD, 4'h5);
    check("strb_model", model[2], 32'h11BB33DD);
    do_read(32'h8);
    drain();

    // W ahead of AW
    model_write(32'hC, 32'h0BADCAFE, 4'hF);
    bus.wdata = 32'h0BADCAFE; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    handshake();
    for (int i = 0; i < 3; i++) begin
      check("w_first_wready", 32'(bus.wready), 32'd0);
      check("w_first_bvalid", 32'(bus.bvalid), 32'd0);
      @(posedge aclk); #1;
    end
    bus.awaddr = 32'hC; bus.awvalid = 1'b1;
    handshake();
    do_read(32'hC);
    drain();

    // Write response backpressure: second write held with both holds full
    bus.bready = 1'b0;
    do_write(32'h8, 32'h55667788, 4'hF);
    wait_valid("b_stall_valid", 1'b0);
    do_write(32'hC, 32'h01020304, 4'hF);
    for (int i = 0; i < 4; i++) begin
      check("bstall_bvalid",  32'(bus.bvalid),  32'd1);
      check("bstall_bresp",   32'(bus.bresp),   32'(OKAY));
      check("bstall_awready", 32'(bus.awready), 32'd0);
      check("bstall_wready",  32'(bus.wready),  32'd0);
      @(posedge aclk); #1;
    end
    bus.bready = 1'b1;
    drain();
    do_read(32'h8);
    do_read(32'hC);
    drain();

    // Read response backpressure
    bus.rready = 1'b0;
    do_read(32'h4);
    wait_valid("r_stall_valid", 1'b1);
    do_read(32'h8);
    check("rstall_arready", 32'(bus.arready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      check("rstall_rvalid", 32'(bus.rvalid), 32'd1);
      check("rstall_rdata",  bus.rdata,       rq[0]);
      @(posedge aclk); #1;
    end
    bus.rready = 1'b1;
    drain();

    // Aliasing modulo SIZE
    do_write(32'h0, 32'hCAFEF00D, 4'hF);
    do_read(32'h10);
    do_read(32'h13);
    drain();

    // Async reset with AW held and a read response stalled
    bus.rready = 1'b0;
    bus.awaddr = 32'h8; bus.awvalid = 1'b1;
    @(posedge aclk); #1;
    check("pre_rst_awready", 32'(bus.awready), 32'd0);
    bus.araddr = 32'h4; bus.arvalid = 1'b1;
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
    wait_valid("pre_rst_rvalid", 1'b1);
    #2 areset = 1'b1;
    #1;
    check("arst_bvalid",  32'(bus.bvalid),  32'd0);
    check("arst_rvalid",  32'(bus.rvalid),  32'd0);
    check("arst_awready", 32'(bus.awready), 32'd1);
    check("arst_wready",  32'(bus.wready),  32'd1);
    check("arst_arready", 32'(bus.arready), 32'd1);
    check("arst_rdata",   bus.rdata,        32'd0);
    bus.awvalid = 1'b0;
    @(posedge aclk); #1;
    areset = 1'b0;
    bus.rready = 1'b1;
    check("retained_model", model[1], 32'hDEADBEEF);
    do_read(32'h4);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
